store_fifo: RTL and testbench
=============================

Name: store_fifo

Overview:
- Store buffer directly downstream of the pipeline's commit-stage data-write port (datafifo_* signals).
- Accepts committed stores, queues them in order, and drains them one per handshake to the data memory write port.
- Converts each store to byte-lane-aligned data plus byte strobes.
- Back-pressures commit through datafifo_full.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write index width. Pointers carry one extra wrap bit.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- datafifo_addr_in  input  32  store byte address from commit
- datafifo_val_in  input  32  store value from commit, right-justified
- datafifo_size_in  input  2  store size: 0 = byte, 1 = half, 2 = word, 3 = reserved
- datafifo_valid_in  input  1  push request
- datafifo_full  output  1  no free entry
- mem_write_addr  output  32  head entry word address, with bits [1:0] forced to 0
- mem_write_data  output  32  head entry lane-aligned data
- mem_write_strb  output  4  head entry byte strobes
- mem_write_valid  output  1  head entry present
- mem_write_ready  input  1  memory accepts the head entry
- empty  output  1  no entries held
- count  output  PTR_W+1  number of entries held
- error_overflow  output  1  sticky: push attempted while full
- error_format  output  1  sticky: reserved size or misaligned store dropped
- load_check_addr  input  32  load byte address to check (feature only)
- load_hazard  output  1  pending store overlaps the load word (feature only)

Behaviour:
- Reset (synchronous, active-high):
  - pointers, count and both error flags go to 0;
  - empty = 1, datafifo_full = 0, mem_write_valid = 0, load_hazard = 0;
  - entries in flight are discarded, including one mid-handshake.
- Storage and flags:
  - Circular buffer of DEPTH entries; each entry holds {word address [31:2], data [31:0], strobe [3:0]}.
  - count = wr_ptr - rd_ptr, using the wrap bit.
  - datafifo_full = (count == DEPTH); empty = (count == 0). Both are combinational from the registered pointers.
- Push: datafifo_valid_in && !datafifo_full && format OK. The entry is written at the clock edge.
  - Full is evaluated before the same-cycle pop; there is no full-bypass.
  - Push while full: the store is dropped and error_overflow is set.
- Format check and lane alignment:
  - Lane shift = addr[1:0]*8.
  - Byte: strobe = 4'b0001 << addr[1:0]; data = val[7:0] shifted to its lane.
  - Half: legal only if addr[0] == 0; strobe = 4'b0011 << addr[1:0]; data = val[15:0] shifted to its lane.
  - Word: legal only if addr[1:0] == 0; strobe = 4'b1111; data = val.
  - Reserved size or misaligned: not stored, pointers unchanged, error_format set.
- Pop:
  - mem_write_valid = !empty. Head fields are driven combinationally from storage.
  - Handshake completes when mem_write_valid && mem_write_ready at the edge; rd_ptr then increments.
  - Head fields stay stable while valid && !ready.
  - First-word latency: a store pushed at edge N is visible at the output after edge N (1 cycle).
- Simultaneous push and pop (not full): both pointers advance and count is unchanged.
- Pointer wrap at DEPTH relies on the modulo arithmetic of the wrap bit; no special case.
- Error flags are sticky until reset.
- Ordering: strict FIFO; entries are never merged or reordered.

Optional Feature:
- Macro STORE_FIFO_LOAD_HAZARD_EN.
- Enabled:
  - load_hazard = 1 combinationally when any occupied entry has word address == load_check_addr[31:2];
  - the head entry counts even while it is mid-handshake;
  - the execute stage stalls loads on this signal.
- Disabled: load_hazard is tied to 0, load_check_addr is unused, and the compare logic is absent.

Decomposition:
- Package store_fifo_pkg:
  - enum store_size_t {SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2, SZ_RSVD = 3};
  - typedef store_entry_t (packed word address, data, strobe);
  - function store_format_ok(size, addr_lo).
- Sub-module store_lane_align: combinational size/addr/val -> data, strb, ok. Instantiated once on the push path.

Test Plan:
- Byte push addr 0x1003, val 0xAB, ready = 1 -> next cycle mem_write_addr = 0x1000, data = 0xAB000000, strb = 4'b1000, valid = 1; one handshake, then empty = 1.
- DEPTH = 4: push 5 words with ready = 0 -> full = 1 after the 4th; the 5th is dropped and error_overflow = 1; releasing ready drains the 4 entries in order, and count steps 4 -> 0.
- Full FIFO, push and ready in the same cycle -> push is rejected (count 4 -> 3) and error_overflow = 1.
- Half at addr 0x2001 and size 3 at 0x2000 -> neither is stored, error_format = 1, count stays 0.
- Wrap: continuous push/pop over 3*DEPTH words with ready toggling pseudo-randomly -> output sequence matches input exactly.
- With STORE_FIFO_LOAD_HAZARD_EN: pending word 0x3004 held with ready = 0, load_check_addr = 0x3006 -> load_hazard = 1; after it drains -> load_hazard = 0. Without the macro -> load_hazard stays 0.

Source files
------------

// File: rtl/store_fifo_pkg.sv
// Shared types and the store format rule for the commit-side store buffer.
package store_fifo_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } store_size_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } store_entry_t;

  // Halves must sit on an even byte, words on a word boundary.
  function automatic logic store_format_ok(input store_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return !addr_lo[0];
      SZ_WORD: return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Moves a right-justified store value onto its byte lanes and builds the strobes.
module store_lane_align
  import store_fifo_pkg::*;
(
  input  store_size_t size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] val,
  output logic [31:0] data,
  output logic [3:0]  strb,
  output logic        ok
);

  logic [4:0] shift;

  assign shift = {addr_lo, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    data = '0;
    strb = '0;
    ok   = store_format_ok(size, addr_lo);
    case (size)
      SZ_BYTE: begin
        strb = 4'b0001 << addr_lo;
        data = {24'b0, val[7:0]} << shift;
      end
      SZ_HALF: begin
        strb = 4'b0011 << addr_lo;
        data = {16'b0, val[15:0]} << shift;
      end
      SZ_WORD: begin
        strb = 4'b1111;
        data = val;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_fifo.sv
// In-order store buffer between commit and the data memory write port.
// Optional STORE_FIFO_LOAD_HAZARD_EN adds the pending-store/load word compare.
module store_fifo
  import store_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      datafifo_addr_in,
  input  logic [31:0]      datafifo_val_in,
  input  logic [1:0]       datafifo_size_in,
  input  logic             datafifo_valid_in,
  output logic             datafifo_full,
  output logic [31:0]      mem_write_addr,
  output logic [31:0]      mem_write_data,
  output logic [3:0]       mem_write_strb,
  output logic             mem_write_valid,
  input  logic             mem_write_ready,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             error_overflow,
  output logic             error_format,
  input  logic [31:0]      load_check_addr,
  output logic             load_hazard
);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  store_entry_t   mem [DEPTH];
  store_entry_t   head;
  logic [31:0]    al_data;
  logic [3:0]     al_strb;
  logic           al_ok;
  logic           push;
  logic           pop;

  store_lane_align u_align (
    .size    (store_size_t'(datafifo_size_in)),
    .addr_lo (datafifo_addr_in[1:0]),
    .val     (datafifo_val_in),
    .data    (al_data),
    .strb    (al_strb),
    .ok      (al_ok)
  );

  // The wrap bit makes the subtraction distinguish full from empty.
  assign count         = wr_ptr - rd_ptr;
  assign datafifo_full = count == (PTR_W+1)'(DEPTH);
  assign empty         = count == '0;

  assign push = datafifo_valid_in && !datafifo_full && al_ok;
  assign pop  = mem_write_valid && mem_write_ready;

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every reader sees pre-edge values.
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      error_overflow <= 1'b0;
      error_format   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (datafifo_valid_in && datafifo_full) error_overflow <= 1'b1;
      if (datafifo_valid_in && !al_ok)        error_format   <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr[PTR_W-1:0]] <= '{waddr: datafifo_addr_in[31:2], data: al_data, strb: al_strb};
  end

  assign head            = mem[rd_ptr[PTR_W-1:0]];
  assign mem_write_valid = !empty;
  assign mem_write_addr  = {head.waddr, 2'b00};
  assign mem_write_data  = head.data;
  assign mem_write_strb  = head.strb;

`ifdef STORE_FIFO_LOAD_HAZARD_EN
  // Walk occupied slots from the head; the head counts until its handshake completes.
  always_comb begin : hazard_scan
    logic [PTR_W-1:0] idx;
    load_hazard = 1'b0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr[PTR_W-1:0] + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && (mem[idx].waddr == load_check_addr[31:2]))
        load_hazard = 1'b1;
    end
  end
`else
  logic unused_load_check;
  assign unused_load_check = ^load_check_addr;
  assign load_hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_store_fifo.sv
// Scoreboard bench for store_fifo: stimulus queues expected writes, a monitor compares each handshake.
module tb_store_fifo;
  import store_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

`ifdef STORE_FIFO_LOAD_HAZARD_EN
  localparam logic HZ_EXP = 1'b1;
`else
  localparam logic HZ_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      datafifo_addr_in = '0;
  logic [31:0]      datafifo_val_in = '0;
  logic [1:0]       datafifo_size_in = '0;
  logic             datafifo_valid_in = 1'b0;
  logic             datafifo_full;
  logic [31:0]      mem_write_addr;
  logic [31:0]      mem_write_data;
  logic [3:0]       mem_write_strb;
  logic             mem_write_valid;
  logic             mem_write_ready = 1'b0;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             error_overflow;
  logic             error_format;
  logic [31:0]      load_check_addr = '0;
  logic             load_hazard;

  store_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .datafifo_addr_in  (datafifo_addr_in),
    .datafifo_val_in   (datafifo_val_in),
    .datafifo_size_in  (datafifo_size_in),
    .datafifo_valid_in (datafifo_valid_in),
    .datafifo_full     (datafifo_full),
    .mem_write_addr    (mem_write_addr),
    .mem_write_data    (mem_write_data),
    .mem_write_strb    (mem_write_strb),
    .mem_write_valid   (mem_write_valid),
    .mem_write_ready   (mem_write_ready),
    .empty             (empty),
    .count             (count),
    .error_overflow    (error_overflow),
    .error_format      (error_format),
    .load_check_addr   (load_check_addr),
    .load_hazard       (load_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge whenever valid && ready here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_write_valid && mem_write_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with nothing expected",
                   mem_write_addr, mem_write_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", mem_write_addr, e.addr);
          check("wr_data", mem_write_data, e.data);
          check("wr_strb", {28'b0, mem_write_strb}, {28'b0, e.strb});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] val, input store_size_t size);
    datafifo_addr_in  = addr;
    datafifo_val_in   = val;
    datafifo_size_in  = size;
    datafifo_valid_in = 1'b1;
    @(posedge clk);
    #1;
    datafifo_valid_in = 1'b0;
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.strb = strb;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (!empty && t < 200) begin
      cycles(1);
      t++;
    end
    check(name, {31'b0, empty}, 32'd1);
  endtask

  initial begin
    int i;
    int guard;

    // Reset state
    cycles(2);
    @(negedge clk);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, datafifo_full}, 32'd0);
    check("rst_valid", {31'b0, mem_write_valid}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_errors", {30'b0, error_overflow, error_format}, 32'd0);
    check("rst_hazard", {31'b0, load_hazard}, 32'd0);
    reset = 1'b0;
    cycles(1);

    // Byte store to the top lane, one-cycle latency, single handshake
    mem_write_ready = 1'b1;
    expect_wr(32'h1000, 32'hAB00_0000, 4'b1000);
    drive(32'h1003, 32'h0000_00AB, SZ_BYTE);
    @(negedge clk);
    check("byte_valid", {31'b0, mem_write_valid}, 32'd1);
    check("byte_count", {29'b0, count}, 32'd1);
    cycles(1);
    @(negedge clk);
    check("byte_drained", {31'b0, empty}, 32'd1);
    cycles(1);

    // Fill to DEPTH with memory stalled, then overflow
    mem_write_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_wr(32'h100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'b1111);
      drive(32'h100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), SZ_WORD);
      if (k == 3) begin
        @(negedge clk);
        check("fill_full", {31'b0, datafifo_full}, 32'd1);
        check("fill_count", {29'b0, count}, 32'd4);
      end
    end
    @(negedge clk);
    check("ovf_flag", {31'b0, error_overflow}, 32'd1);
    check("ovf_count", {29'b0, count}, 32'd4);
    @(posedge clk);
    #1;
    mem_write_ready = 1'b1;
    for (int c = 4; c >= 0; c--) begin
      @(negedge clk);
      check("drain_count", {29'b0, count}, 32'(c));
    end
    check("drain_empty", {31'b0, empty}, 32'd1);
    cycles(1);

    // Full FIFO: push and pop in the same cycle, push must be rejected
    do_reset();
    @(negedge clk);
    check("rst2_ovf", {31'b0, error_overflow}, 32'd0);
    mem_write_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_wr(32'h200 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'b1111);
      drive(32'h200 + 32'(4 * k), 32'hA000_0000 + 32'(k), SZ_WORD);
    end
    mem_write_ready = 1'b1;
    drive(32'h210, 32'hBAD0_BAD0, SZ_WORD);
    @(negedge clk);
    check("fullpop_count", {29'b0, count}, 32'd3);
    check("fullpop_ovf", {31'b0, error_overflow}, 32'd1);
    wait_empty("fullpop_drain");

    // Format errors, then legal halves/bytes on other lanes
    do_reset();
    drive(32'h2001, 32'h0000_5555, SZ_HALF);
    drive(32'h2000, 32'h0000_0001, SZ_RSVD);
    @(negedge clk);
    check("fmt_flag", {31'b0, error_format}, 32'd1);
    check("fmt_count", {29'b0, count}, 32'd0);
    check("fmt_empty", {31'b0, empty}, 32'd1);
    check("fmt_no_ovf", {31'b0, error_overflow}, 32'd0);
    expect_wr(32'h2000, 32'h1234_0000, 4'b1100);
    drive(32'h2002, 32'h0000_1234, SZ_HALF);
    expect_wr(32'h2000, 32'h0000_EE00, 4'b0010);
    drive(32'h2001, 32'h0000_FFEE, SZ_BYTE);
    expect_wr(32'h2004, 32'hDEAD_BEEF, 4'b1111);
    drive(32'h2004, 32'hDEAD_BEEF, SZ_WORD);
    wait_empty("lanes_drain");

    // Wrap: 3*DEPTH words with ready toggling
    i = 0;
    guard = 0;
    while (i < 3 * DEPTH && guard < 500) begin
      mem_write_ready   = 1'($urandom_range(0, 1));
      datafifo_addr_in  = 32'h4000 + 32'(4 * i);
      datafifo_val_in   = 32'hC0DE_0000 | 32'(i);
      datafifo_size_in  = SZ_WORD;
      datafifo_valid_in = 1'b1;
      @(negedge clk);
      if (!datafifo_full) begin
        expect_wr(32'h4000 + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'b1111);
        i++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    datafifo_valid_in = 1'b0;
    mem_write_ready   = 1'b1;
    check("wrap_all_pushed", 32'(i), 32'(3 * DEPTH));
    wait_empty("wrap_drain");

    // Load hazard against a held store
    mem_write_ready = 1'b0;
    expect_wr(32'h3004, 32'h0000_0077, 4'b1111);
    drive(32'h3004, 32'h0000_0077, SZ_WORD);
    load_check_addr = 32'h3006;
    @(negedge clk);
    check("hz_hit", {31'b0, load_hazard}, {31'b0, HZ_EXP});
    load_check_addr = 32'h3008;
    #1;
    check("hz_other_word", {31'b0, load_hazard}, 32'd0);
    load_check_addr = 32'h3006;
    @(posedge clk);
    #1;
    mem_write_ready = 1'b1;
    wait_empty("hz_drain");
    @(negedge clk);
    check("hz_cleared", {31'b0, load_hazard}, 32'd0);

    cycles(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
